// File: rtl/sbox_scheduler.sv
// sbox_scheduler: four shared AES forward S-box lanes time-multiplexed between
// a 4-pass SubBytes job (128-bit state, one word per pass) and a single-pass
// SubWord job for key expansion.
module sbox_scheduler #(
  parameter bit KEY_PRIORITY = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sb_req,
  input  logic [127:0] sb_in,
  output logic         sb_ack,
  output logic [127:0] sb_out,
  output logic         sb_done,
  input  logic         kw_req,
  input  logic [31:0]  kw_in,
  output logic         kw_ack,
  output logic [31:0]  kw_out,
  output logic         kw_done,
  output logic         busy
);

  localparam int unsigned SB_W   = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(3);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {IDLE, SB_RUN} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   cnt;
  logic [SB_W-1:0]    sb_buf;
  logic [WORD_W-1:0]  kw_buf;
  logic               kw_pending;
  logic               kw_grant;
  logic               sb_grant;
  logic               sb_last;
  logic               sb_accept;
  logic               kw_accept;
  logic [WORD_W-1:0]  lane_word;
  logic [WORD_W-1:0]  lane_res;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Lane arbitration, handshakes and next state
  always_comb begin
    state_nxt = state;
    kw_grant  = 1'b0;
    sb_grant  = 1'b0;
    sb_last   = 1'b0;
    sb_ack    = 1'b0;
    kw_ack    = 1'b0;
    sb_accept = 1'b0;
    kw_accept = 1'b0;

    kw_grant  = kw_pending && (KEY_PRIORITY || (state != SB_RUN));
    sb_grant  = (state == SB_RUN) && !kw_grant;
    sb_last   = sb_grant && (cnt == LAST_IDX);
    sb_ack    = (state == IDLE) || sb_last;
    kw_ack    = !kw_pending || kw_grant;
    sb_accept = sb_req && sb_ack;
    kw_accept = kw_req && kw_ack;

    case (state)
      IDLE:    if (sb_accept) state_nxt = SB_RUN;
      SB_RUN:  if (sb_last && !sb_accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Four S-box lanes fed by whichever job holds the grant
  always_comb begin
    lane_res  = '0;
    lane_word = kw_grant ? kw_buf : sb_buf[{cnt, 5'd0} +: WORD_W];
    for (int i = 0; i < LANES; i++) begin
      lane_res[BYTE_W*i +: BYTE_W] = SBOX[lane_word[BYTE_W*i +: BYTE_W]];
    end
  end

  // Job capture, pass counter, result registers and done pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      sb_buf     <= '0;
      kw_buf     <= '0;
      kw_pending <= 1'b0;
      sb_out     <= '0;
      kw_out     <= '0;
      sb_done    <= 1'b0;
      kw_done    <= 1'b0;
    end else begin
      sb_done <= 1'b0;
      kw_done <= 1'b0;

      if (sb_accept) begin
        sb_buf <= sb_in;
        cnt    <= '0;
      end else if (sb_grant) begin
        cnt <= cnt + IDX_W'(1);
      end

      if (sb_grant) begin
        sb_out[{cnt, 5'd0} +: WORD_W] <= lane_res;
        sb_done                       <= sb_last;
      end

      if (kw_grant) begin
        kw_out  <= lane_res;
        kw_done <= 1'b1;
      end

      if (kw_accept) begin
        kw_buf     <= kw_in;
        kw_pending <= 1'b1;
      end else if (kw_grant) begin
        kw_pending <= 1'b0;
      end
    end
  end

  assign busy = (state == SB_RUN) || kw_pending;

endmodule

// File: tb/tb_sbox_scheduler.sv
// Bench for sbox_scheduler: one instance per KEY_PRIORITY setting, each checked
// every cycle against a job-level model whose S-box is derived from GF(2^8).
module tb_sbox_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   sb_req, sb_ack, sb_done, kw_req, kw_ack, kw_done, busy;
  logic [127:0] sb_in  [2];
  logic [127:0] sb_out [2];
  logic [31:0]  kw_in  [2];
  logic [31:0]  kw_out [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sbox_scheduler #(.KEY_PRIORITY(1'b1)) u_kp1 (
    .clk(clk), .rst(rst),
    .sb_req(sb_req[0]), .sb_in(sb_in[0]), .sb_ack(sb_ack[0]), .sb_out(sb_out[0]), .sb_done(sb_done[0]),
    .kw_req(kw_req[0]), .kw_in(kw_in[0]), .kw_ack(kw_ack[0]), .kw_out(kw_out[0]), .kw_done(kw_done[0]),
    .busy(busy[0])
  );

  sbox_scheduler #(.KEY_PRIORITY(1'b0)) u_kp0 (
    .clk(clk), .rst(rst),
    .sb_req(sb_req[1]), .sb_in(sb_in[1]), .sb_ack(sb_ack[1]), .sb_out(sb_out[1]), .sb_done(sb_done[1]),
    .kw_req(kw_req[1]), .kw_in(kw_in[1]), .kw_ack(kw_ack[1]), .kw_out(kw_out[1]), .kw_done(kw_done[1]),
    .busy(busy[1])
  );

  // S-box built from multiplicative inverse plus affine transform
  logic [7:0] stab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      stab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = stab[w[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] subbytes(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = stab[v[8*i +: 8]];
    return r;
  endfunction

  // Behavioural model, index 0 = key priority, index 1 = SubBytes priority
  bit           m_run    [2];
  int           m_words  [2];
  logic [127:0] m_res    [2];
  logic [127:0] m_sbo    [2];
  bit           m_pend   [2];
  logic [31:0]  m_kwd    [2];
  logic [31:0]  m_kwo    [2];
  bit           m_sbdone [2];
  bit           m_kwdone [2];

  function automatic bit m_kwgo(input int d);
    return m_pend[d] && (d == 0 || !m_run[d]);
  endfunction

  function automatic bit m_sb_ack(input int d);
    return !m_run[d] || (!m_kwgo(d) && m_words[d] == 3);
  endfunction

  function automatic bit m_kw_ack(input int d);
    return !m_pend[d] || m_kwgo(d);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_words[d] = 0; m_res[d] = '0; m_sbo[d] = '0;
      m_pend[d] = 0; m_kwd[d] = '0; m_kwo[d] = '0; m_sbdone[d] = 0; m_kwdone[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    bit kwgo, sbgo, sa, ka;
    kwgo = m_kwgo(d);
    sbgo = m_run[d] && !kwgo;
    sa   = sb_req[d] && m_sb_ack(d);
    ka   = kw_req[d] && m_kw_ack(d);
    m_sbdone[d] = 0;
    m_kwdone[d] = 0;
    if (sbgo) begin
      m_sbo[d][32*m_words[d] +: 32] = m_res[d][32*m_words[d] +: 32];
      m_words[d]++;
      if (m_words[d] == 4) begin
        m_sbdone[d] = 1;
        m_run[d]    = 0;
      end
    end
    if (kwgo) begin
      m_kwo[d]    = subword(m_kwd[d]);
      m_kwdone[d] = 1;
      m_pend[d]   = 0;
    end
    if (sa) begin
      m_run[d]   = 1;
      m_words[d] = 0;
      m_res[d]   = subbytes(sb_in[d]);
    end
    if (ka) begin
      m_pend[d] = 1;
      m_kwd[d]  = kw_in[d];
    end
  endtask

  task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk("sb_ack",  d, 128'(sb_ack[d]),  128'(m_sb_ack(d)));
      chk("kw_ack",  d, 128'(kw_ack[d]),  128'(m_kw_ack(d)));
      chk("sb_done", d, 128'(sb_done[d]), 128'(m_sbdone[d]));
      chk("kw_done", d, 128'(kw_done[d]), 128'(m_kwdone[d]));
      chk("busy",    d, 128'(busy[d]),    128'(m_run[d] | m_pend[d]));
      chk("sb_out",  d, sb_out[d], m_sbo[d]);
      chk("kw_out",  d, 128'(kw_out[d]), 128'(m_kwo[d]));
    end
  endtask

  // One clock edge: advance model with current inputs, then compare at negedge
  task automatic tick();
    for (int d = 0; d < 2; d++) model_step(d);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  int first_sb [2];
  int first_kw [2];

  task automatic record(input int t0, input int n);
    for (int d = 0; d < 2; d++) begin first_sb[d] = -1; first_kw[d] = -1; end
    for (int t = t0; t < t0 + n; t++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        if (sb_done[d] && first_sb[d] < 0) first_sb[d] = t;
        if (kw_done[d] && first_kw[d] < 0) first_kw[d] = t;
      end
    end
  endtask

  task automatic idle(input int n);
    sb_req = 2'b00; kw_req = 2'b00;
    for (int i = 0; i < n; i++) tick();
  endtask

  localparam logic [127:0] V1 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] R1 = 128'h76abd7fe2b670130c56f6bf27b777c63;
  localparam logic [127:0] V2 = 128'h1f1e1d1c1b1a19181716151413121110;
  localparam logic [127:0] R2 = 128'hc072a49cafa2d4adf04759fa7dc982ca;

  initial begin
    int acc_cnt [2];
    int acc2_t  [2];
    int dn_t    [2][2];
    int nd      [2];
    bit sa [2];

    build_sbox();
    rst = 1'b1;
    sb_req = 2'b00; kw_req = 2'b00;
    for (int d = 0; d < 2; d++) begin sb_in[d] = '0; kw_in[d] = '0; end
    model_reset();

    // Model self-pins against known AES values
    chk("model_subword", 0, 128'(subword(32'hcf4f3c09)), 128'(32'h8a84eb01));
    chk("model_subbytes", 0, subbytes(V2), R2);

    #2;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // SubBytes alone: done 4 edges after accept
    sb_req = 2'b11; sb_in[0] = V1; sb_in[1] = V1;
    tick();
    sb_req = 2'b00;
    record(1, 6);
    for (int d = 0; d < 2; d++) begin
      chk("sb_alone_latency", d, 128'(first_sb[d]), 128'(4));
      chk("sb_alone_result",  d, sb_out[d], R1);
    end

    // Key word alone: done 1 edge after accept
    kw_req = 2'b11; kw_in[0] = 32'hcf4f3c09; kw_in[1] = 32'hcf4f3c09;
    tick();
    kw_req = 2'b00;
    record(1, 3);
    for (int d = 0; d < 2; d++) begin
      chk("kw_alone_latency", d, 128'(first_kw[d]), 128'(1));
      chk("kw_alone_result",  d, 128'(kw_out[d]), 128'(32'h8a84eb01));
    end
    idle(2);

    // Contention: kw accepted on the edge of SubBytes pass 0
    sb_req = 2'b11; sb_in[0] = V2; sb_in[1] = V2;
    tick();
    sb_req = 2'b00;
    kw_req = 2'b11; kw_in[0] = 32'h00010203; kw_in[1] = 32'h00010203;
    tick();
    kw_req = 2'b00;
    record(2, 7);
    chk("kp1_kw_latency", 0, 128'(first_kw[0]), 128'(2));
    chk("kp1_sb_latency", 0, 128'(first_sb[0]), 128'(5));
    chk("kp0_sb_latency", 1, 128'(first_sb[1]), 128'(4));
    chk("kp0_kw_latency", 1, 128'(first_kw[1]), 128'(5));
    for (int d = 0; d < 2; d++) begin
      chk("contend_sb_result", d, sb_out[d], R2);
      chk("contend_kw_result", d, 128'(kw_out[d]), 128'(32'h637c777b));
    end
    idle(2);

    // Back-to-back SubBytes with request held
    sb_req = 2'b11; sb_in[0] = V1; sb_in[1] = V1;
    for (int d = 0; d < 2; d++) begin acc_cnt[d] = 0; acc2_t[d] = -1; nd[d] = 0; end
    for (int t = 0; t < 11; t++) begin
      for (int d = 0; d < 2; d++) sa[d] = sb_req[d] && sb_ack[d];
      tick();
      for (int d = 0; d < 2; d++) begin
        if (sb_done[d] && nd[d] < 2) begin dn_t[d][nd[d]] = t; nd[d]++; end
        if (sa[d]) begin
          acc_cnt[d]++;
          if (acc_cnt[d] == 1) sb_in[d] = V2;
          if (acc_cnt[d] == 2) begin acc2_t[d] = t; sb_req[d] = 1'b0; end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      chk("b2b_second_accept", d, 128'(acc2_t[d]), 128'(4));
      chk("b2b_done_count",    d, 128'(nd[d]), 128'(2));
      if (nd[d] == 2) chk("b2b_done_spacing", d, 128'(dn_t[d][1] - dn_t[d][0]), 128'(4));
      chk("b2b_result", d, sb_out[d], R2);
    end
    idle(2);

    // Reset mid-job: everything clears without a clock
    sb_req = 2'b11; sb_in[0] = V1; sb_in[1] = V1;
    kw_req = 2'b11; kw_in[0] = 32'h12345678; kw_in[1] = 32'h12345678;
    tick();
    sb_req = 2'b00; kw_req = 2'b00;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    for (int d = 0; d < 2; d++) begin
      chk("rst_sb_out", d, sb_out[d], 128'h0);
      chk("rst_busy",   d, 128'(busy[d]), 128'(0));
      chk("rst_acks",   d, 128'({sb_ack[d], kw_ack[d]}), 128'(2'b11));
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;
    record(0, 5);
    for (int d = 0; d < 2; d++) chk("rst_no_done", d, 128'(first_sb[d]), 128'(-1));
    sb_req = 2'b11; sb_in[0] = V2; sb_in[1] = V2;
    tick();
    sb_req = 2'b00;
    record(1, 6);
    for (int d = 0; d < 2; d++) begin
      chk("post_rst_latency", d, 128'(first_sb[d]), 128'(4));
      chk("post_rst_result",  d, sb_out[d], R2);
    end

    // Randomized traffic on both instances
    for (int t = 0; t < 3000; t++) begin
      for (int d = 0; d < 2; d++) begin
        if (!sb_req[d] && $urandom_range(0, 3) == 0) begin
          sb_req[d] = 1'b1;
          sb_in[d]  = {$urandom, $urandom, $urandom, $urandom};
        end
        if (!kw_req[d] && $urandom_range(0, 2) == 0) begin
          kw_req[d] = 1'b1;
          kw_in[d]  = $urandom;
        end
      end
      sa[0] = sb_req[0] && sb_ack[0];
      sa[1] = sb_req[1] && sb_ack[1];
      acc_cnt[0] = int'(kw_req[0] && kw_ack[0]);
      acc_cnt[1] = int'(kw_req[1] && kw_ack[1]);
      tick();
      for (int d = 0; d < 2; d++) begin
        if (sa[d]) sb_req[d] = 1'b0;
        if (acc_cnt[d] != 0) kw_req[d] = 1'b0;
      end
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
